// File: rtl/datapath_sequencer.sv
// Instruction sequencer for the regfile/ALU datapath; optional SEQ_STATS_EN adds retire/skip counters.
// Latency: accept edge -> EXEC controls next cycle, Wen one cycle later; 1 ALU instr per 3 cycles.
// Backpressure: InstrReady only in FETCH/SKIP; Instr must stay stable while InstrValid && !InstrReady.
module datapath_sequencer #(
    parameter int REG_AW = 4,
    parameter int OP_W   = 3,
    parameter int SEL_W  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              InstrValid,
    output logic              InstrReady,
    input  logic [15:0]       Instr,
    input  logic              Restart,
    input  logic              Flag,
    output logic              Wen,
    output logic [REG_AW-1:0] WA,
    output logic [REG_AW-1:0] RAA,
    output logic [REG_AW-1:0] RAB,
    output logic [OP_W-1:0]   Op,
    output logic [SEL_W-1:0]  Sel,
    output logic              Busy,
    output logic              Halted,
`ifdef SEQ_STATS_EN
    output logic [15:0]       RetireCount,
    output logic [15:0]       SkipCount,
`endif
    output logic              Error
);

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_EXEC,
        ST_WB,
        ST_SKIP,
        ST_HALT
    } state_t;

    localparam logic [3:0] OPC_ADD  = 4'h0;
    localparam logic [3:0] OPC_SUB  = 4'h1;
    localparam logic [3:0] OPC_AND  = 4'h3;
    localparam logic [3:0] OPC_MOV  = 4'h4;
    localparam logic [3:0] OPC_LDI  = 4'h8;
    localparam logic [3:0] OPC_BRF  = 4'h9;
    localparam logic [3:0] OPC_HALT = 4'hF;

    localparam logic [OP_W-1:0] OP_ADD = OP_W'(3'b000);
    localparam logic [OP_W-1:0] OP_SUB = OP_W'(3'b001);
    localparam logic [OP_W-1:0] OP_NOP = OP_W'(3'b010);
    localparam logic [OP_W-1:0] OP_AND = OP_W'(3'b011);
    localparam logic [OP_W-1:0] OP_MOV = OP_W'(3'b100);

    state_t            state_q, state_d;
    logic              wen_q, wen_d;
    logic [REG_AW-1:0] wa_q, wa_d;
    logic [REG_AW-1:0] raa_q, raa_d;
    logic [REG_AW-1:0] rab_q, rab_d;
    logic [REG_AW-1:0] dst_q, dst_d;
    logic [OP_W-1:0]   op_q, op_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic [3:0]        skip_cnt_q, skip_cnt_d;
    logic              error_q, error_d;
    logic              ready_q, ready_d;
    logic              busy_q, busy_d;
    logic              halted_q, halted_d;

    logic [3:0] opc, f_dst, f_srca, f_srcb;
    logic       xfer;
    logic       restart_take;

    assign opc          = Instr[15:12];
    assign f_dst        = Instr[11:8];
    assign f_srca       = Instr[7:4];
    assign f_srcb       = Instr[3:0];
    assign xfer         = InstrValid && ready_q;
    assign restart_take = (state_q == ST_HALT) && Restart;

    always_comb begin
        state_d    = state_q;
        wen_d      = 1'b0;
        wa_d       = wa_q;
        raa_d      = raa_q;
        rab_d      = rab_q;
        dst_d      = dst_q;
        op_d       = op_q;
        sel_d      = sel_q;
        skip_cnt_d = skip_cnt_q;
        error_d    = error_q;
        case (state_q)
            ST_FETCH: begin
                if (xfer) begin
                    case (opc)
                        OPC_ADD, OPC_SUB, OPC_AND, OPC_MOV: begin
                            raa_d   = REG_AW'(f_srca);
                            rab_d   = REG_AW'(f_srcb);
                            dst_d   = REG_AW'(f_dst);
                            sel_d   = '0;
                            state_d = ST_EXEC;
                            case (opc)
                                OPC_ADD: op_d = OP_ADD;
                                OPC_SUB: op_d = OP_SUB;
                                OPC_AND: op_d = OP_AND;
                                default: op_d = OP_MOV;
                            endcase
                        end
                        // LDI routes the input port selected by srcA through the MOV path
                        OPC_LDI: begin
                            raa_d   = '0;
                            rab_d   = REG_AW'(f_srcb);
                            dst_d   = REG_AW'(f_dst);
                            sel_d   = SEL_W'(f_srca);
                            op_d    = OP_MOV;
                            state_d = ST_EXEC;
                        end
                        OPC_BRF: begin
                            if (Flag && (f_srcb != 4'd0)) begin
                                skip_cnt_d = f_srcb;
                                state_d    = ST_SKIP;
                            end
                        end
                        OPC_HALT: state_d = ST_HALT;
                        default: begin
                            error_d = 1'b1;
                            state_d = ST_HALT;
                        end
                    endcase
                end
            end
            ST_EXEC: begin
                wen_d   = 1'b1;
                wa_d    = dst_q;
                state_d = ST_WB;
            end
            ST_WB: begin
                op_d    = OP_NOP;
                state_d = ST_FETCH;
            end
            ST_SKIP: begin
                if (xfer) begin
                    skip_cnt_d = skip_cnt_q - 4'd1;
                    if (skip_cnt_q == 4'd1) state_d = ST_FETCH;
                end
            end
            ST_HALT: begin
                if (Restart) begin
                    error_d = 1'b0;
                    state_d = ST_FETCH;
                end
            end
            default: state_d = ST_FETCH;
        endcase
        // Status outputs are registered from the next state so they never glitch
        ready_d  = (state_d == ST_FETCH) || (state_d == ST_SKIP);
        busy_d   = (state_d == ST_EXEC) || (state_d == ST_WB) || (state_d == ST_SKIP);
        halted_d = (state_d == ST_HALT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_FETCH;
            wen_q      <= 1'b0;
            wa_q       <= '0;
            raa_q      <= '0;
            rab_q      <= '0;
            dst_q      <= '0;
            op_q       <= OP_NOP;
            sel_q      <= '0;
            skip_cnt_q <= '0;
            error_q    <= 1'b0;
            ready_q    <= 1'b1;
            busy_q     <= 1'b0;
            halted_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            wen_q      <= wen_d;
            wa_q       <= wa_d;
            raa_q      <= raa_d;
            rab_q      <= rab_d;
            dst_q      <= dst_d;
            op_q       <= op_d;
            sel_q      <= sel_d;
            skip_cnt_q <= skip_cnt_d;
            error_q    <= error_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
            halted_q   <= halted_d;
        end
    end

    assign InstrReady = ready_q;
    assign Wen        = wen_q;
    assign WA         = wa_q;
    assign RAA        = raa_q;
    assign RAB        = rab_q;
    assign Op         = op_q;
    assign Sel        = sel_q;
    assign Busy       = busy_q;
    assign Halted     = halted_q;
    assign Error      = error_q;

`ifdef SEQ_STATS_EN
    logic [15:0] retire_cnt_q, retire_cnt_d;
    logic [15:0] skip_stat_q, skip_stat_d;

    always_comb begin
        retire_cnt_d = retire_cnt_q;
        skip_stat_d  = skip_stat_q;
        if (restart_take) begin
            retire_cnt_d = '0;
            skip_stat_d  = '0;
        end else begin
            if ((state_q == ST_WB) && (retire_cnt_q != 16'hFFFF))
                retire_cnt_d = retire_cnt_q + 16'd1;
            if ((state_q == ST_SKIP) && xfer && (skip_stat_q != 16'hFFFF))
                skip_stat_d = skip_stat_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retire_cnt_q <= '0;
            skip_stat_q  <= '0;
        end else begin
            retire_cnt_q <= retire_cnt_d;
            skip_stat_q  <= skip_stat_d;
        end
    end

    assign RetireCount = retire_cnt_q;
    assign SkipCount   = skip_stat_q;
`else
    logic unused_restart_take;
    assign unused_restart_take = restart_take;
`endif

endmodule

// File: tb/tb_datapath_sequencer.sv
// Self-checking bench for datapath_sequencer: scoreboard of expected write-backs plus per-scenario checks.
module tb_datapath_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        InstrValid;
    logic        InstrReady;
    logic [15:0] Instr;
    logic        Restart;
    logic        Flag;
    logic        Wen;
    logic [3:0]  WA, RAA, RAB;
    logic [2:0]  Op;
    logic [3:0]  Sel;
    logic        Busy, Halted, Error;
`ifdef SEQ_STATS_EN
    logic [15:0] RetireCount, SkipCount;
`endif

    always #5 clk = ~clk;

    datapath_sequencer dut (
        .clk(clk), .rst_n(rst_n),
        .InstrValid(InstrValid), .InstrReady(InstrReady), .Instr(Instr),
        .Restart(Restart), .Flag(Flag),
        .Wen(Wen), .WA(WA), .RAA(RAA), .RAB(RAB), .Op(Op), .Sel(Sel),
        .Busy(Busy), .Halted(Halted),
`ifdef SEQ_STATS_EN
        .RetireCount(RetireCount), .SkipCount(SkipCount),
`endif
        .Error(Error)
    );

    typedef struct packed {
        logic [3:0] wa;
        logic [3:0] raa;
        logic [3:0] rab;
        logic [2:0] op;
        logic [3:0] sel;
    } wb_t;

    int  errors = 0;
    int  checks = 0;
    wb_t sb[$];
    wb_t exp_w, got_w;

    // Expected write-back controls for an instruction that executes
    function automatic wb_t exp_of(input logic [15:0] ins);
        wb_t e;
        e.wa  = ins[11:8];
        e.raa = ins[7:4];
        e.rab = ins[3:0];
        e.sel = 4'h0;
        case (ins[15:12])
            4'h0: e.op = 3'b000;
            4'h1: e.op = 3'b001;
            4'h3: e.op = 3'b011;
            4'h4: e.op = 3'b100;
            4'h8: begin e.op = 3'b100; e.raa = 4'h0; e.sel = ins[7:4]; end
            default: e.op = 3'b010;
        endcase
        return e;
    endfunction

    always @(negedge clk) begin
        if (rst_n && Wen) begin
            checks++;
            got_w = '{wa: WA, raa: RAA, rab: RAB, op: Op, sel: Sel};
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL wb_unexpected: Wen=1 WA=%h got %h, no write expected", WA, got_w);
            end else begin
                exp_w = sb.pop_front();
                if (got_w !== exp_w) begin
                    errors++;
                    $display("FAIL wb_controls: got %h want %h", got_w, exp_w);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] ins, output int edges);
        InstrValid = 1'b1;
        Instr      = ins;
        edges      = 0;
        while (!InstrReady && edges < 20) begin
            tick();
            edges++;
        end
        checks++;
        if (!InstrReady) begin
            errors++;
            $display("FAIL send_timeout: instr %h not accepted, InstrReady=%b want 1", ins, InstrReady);
        end else begin
            tick();
            edges++;
        end
        InstrValid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; InstrValid = 1'b0; Instr = 16'h0; Restart = 1'b0; Flag = 1'b0;
        repeat (2) tick();
        checks++;
        if ({Wen, Op, InstrReady, Halted, Error, Busy, WA, RAA, RAB, Sel} !==
            {1'b0, 3'b010, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000}) begin
            errors++;
            $display("FAIL reset_hold: got %h want %h",
                {Wen, Op, InstrReady, Halted, Error, Busy, WA, RAA, RAB, Sel},
                {1'b0, 3'b010, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000});
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if ({Wen, Op, InstrReady, Halted, Error, Busy} !== {1'b0, 3'b010, 1'b1, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_release: got %b want %b",
                {Wen, Op, InstrReady, Halted, Error, Busy}, {1'b0, 3'b010, 1'b1, 1'b0, 1'b0, 1'b0});
        end
`ifdef SEQ_STATS_EN
        checks++;
        if ({RetireCount, SkipCount} !== 32'h0) begin
            errors++;
            $display("FAIL reset_stats: got %h want 0", {RetireCount, SkipCount});
        end
`endif
    endtask

    task automatic test_add();
        int edges;
        sb.push_back(exp_of(16'h0312));
        send(16'h0312, edges);
        checks++;
        if (edges !== 1) begin errors++; $display("FAIL add_accept: edges %0d want 1", edges); end
        checks++;
        if ({RAA, RAB, Op, Wen, Busy, InstrReady} !== {4'h1, 4'h2, 3'b000, 1'b0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL add_exec: got %h want %h", {RAA, RAB, Op, Wen, Busy, InstrReady},
                {4'h1, 4'h2, 3'b000, 1'b0, 1'b1, 1'b0});
        end
        tick();
        checks++;
        if ({Wen, WA, Op, Busy} !== {1'b1, 4'h3, 3'b000, 1'b1}) begin
            errors++;
            $display("FAIL add_wb: got %h want %h", {Wen, WA, Op, Busy}, {1'b1, 4'h3, 3'b000, 1'b1});
        end
        tick();
        checks++;
        if ({Wen, Op, InstrReady, Busy, WA} !== {1'b0, 3'b010, 1'b1, 1'b0, 4'h3}) begin
            errors++;
            $display("FAIL add_done: got %h want %h", {Wen, Op, InstrReady, Busy, WA},
                {1'b0, 3'b010, 1'b1, 1'b0, 4'h3});
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] prog [4] = '{16'h1123, 16'h3456, 16'h4789, 16'h8A5B};
        int edges;
        for (int i = 0; i < 4; i++) begin
            sb.push_back(exp_of(prog[i]));
            send(prog[i], edges);
            if (i > 0) begin
                checks++;
                if (edges !== 3) begin
                    errors++;
                    $display("FAIL b2b_spacing: instr %0d edges %0d want 3", i, edges);
                end
            end
        end
        checks++;
        if ({RAA, RAB, Sel, Op} !== {4'h0, 4'hB, 4'h5, 3'b100}) begin
            errors++;
            $display("FAIL ldi_exec: got %h want %h", {RAA, RAB, Sel, Op}, {4'h0, 4'hB, 4'h5, 3'b100});
        end
        repeat (2) tick();
    endtask

    task automatic test_brf_taken();
        int edges;
`ifdef SEQ_STATS_EN
        logic [15:0] rt0 = RetireCount;
        logic [15:0] sk0 = SkipCount;
`endif
        sb.push_back(exp_of(16'h1012));
        send(16'h1012, edges);
        tick();
        Flag = 1'b1;
        send(16'h9002, edges);
        checks++;
        if ({Busy, InstrReady, Op, Wen} !== {1'b1, 1'b1, 3'b010, 1'b0}) begin
            errors++;
            $display("FAIL brf_skip_enter: got %b want %b", {Busy, InstrReady, Op, Wen}, {1'b1, 1'b1, 3'b010, 1'b0});
        end
        send(16'h0111, edges);
        checks++;
        if ({Busy, Wen, Op} !== {1'b1, 1'b0, 3'b010}) begin
            errors++;
            $display("FAIL brf_discard1: got %b want %b", {Busy, Wen, Op}, {1'b1, 1'b0, 3'b010});
        end
        send(16'h0222, edges);
        checks++;
        if ({Busy, InstrReady, Wen} !== {1'b0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL brf_discard2: got %b want %b", {Busy, InstrReady, Wen}, {1'b0, 1'b1, 1'b0});
        end
        sb.push_back(exp_of(16'h0333));
        send(16'h0333, edges);
        tick();
        checks++;
        if ({Wen, WA} !== {1'b1, 4'h3}) begin
            errors++;
            $display("FAIL brf_third_wb: got %h want %h", {Wen, WA}, {1'b1, 4'h3});
        end
        tick();
`ifdef SEQ_STATS_EN
        checks++;
        if ({SkipCount - sk0, RetireCount - rt0} !== {16'd2, 16'd2}) begin
            errors++;
            $display("FAIL brf_stats: got skip %0d retire %0d want 2 2", SkipCount - sk0, RetireCount - rt0);
        end
`endif
    endtask

    task automatic test_skip_discard();
        int edges;
        send(16'h9003, edges);
        send(16'hF000, edges);
        send(16'h5000, edges);
        send(16'h9001, edges);
        checks++;
        if ({Halted, Error, Busy, InstrReady} !== 4'b0001) begin
            errors++;
            $display("FAIL skip_discard_ctrl: got %b want 0001", {Halted, Error, Busy, InstrReady});
        end
        send(16'h9000, edges);
        checks++;
        if ({Busy, InstrReady} !== 2'b01) begin
            errors++;
            $display("FAIL brf_zero_n: got %b want 01", {Busy, InstrReady});
        end
        sb.push_back(exp_of(16'h0A12));
        send(16'h0A12, edges);
        repeat (2) tick();
    endtask

    task automatic test_brf_not_taken();
        int edges;
        sb.push_back(exp_of(16'h1011));
        send(16'h1011, edges);
        tick();
        Flag = 1'b0;
        send(16'h9005, edges);
        checks++;
        if ({Busy, InstrReady, Halted} !== 3'b010) begin
            errors++;
            $display("FAIL brf_not_taken: got %b want 010", {Busy, InstrReady, Halted});
        end
        sb.push_back(exp_of(16'h0456));
        send(16'h0456, edges);
        checks++;
        if ({edges[3:0], RAA, RAB, Op} !== {4'd1, 4'h5, 4'h6, 3'b000}) begin
            errors++;
            $display("FAIL brf_nt_next_exec: got %h want %h", {edges[3:0], RAA, RAB, Op}, {4'd1, 4'h5, 4'h6, 3'b000});
        end
        tick();
        checks++;
        if ({Wen, WA} !== {1'b1, 4'h4}) begin
            errors++;
            $display("FAIL brf_nt_next_wb: got %h want %h", {Wen, WA}, {1'b1, 4'h4});
        end
        tick();
    endtask

    task automatic test_illegal_halt();
        int edges;
        send(16'h5000, edges);
        InstrValid = 1'b1;
        Instr      = 16'h0123;
        for (int c = 0; c < 3; c++) begin
            checks++;
            if ({Halted, Error, InstrReady, Busy} !== 4'b1100) begin
                errors++;
                $display("FAIL illegal_halt: cycle %0d got %b want 1100", c, {Halted, Error, InstrReady, Busy});
            end
            tick();
        end
        Restart = 1'b1;
        tick();
        Restart    = 1'b0;
        InstrValid = 1'b0;
        checks++;
        if ({Halted, Error, InstrReady, Busy} !== 4'b0010) begin
            errors++;
            $display("FAIL restart_clear: got %b want 0010", {Halted, Error, InstrReady, Busy});
        end
`ifdef SEQ_STATS_EN
        checks++;
        if ({RetireCount, SkipCount} !== 32'h0) begin
            errors++;
            $display("FAIL restart_stats: got %h want 0", {RetireCount, SkipCount});
        end
`endif
        send(16'hF000, edges);
        checks++;
        if ({Halted, Error, InstrReady} !== 3'b100) begin
            errors++;
            $display("FAIL halt_op: got %b want 100", {Halted, Error, InstrReady});
        end
        tick();
        Restart = 1'b1;
        tick();
        Restart = 1'b0;
        checks++;
        if ({Halted, InstrReady} !== 2'b01) begin
            errors++;
            $display("FAIL halt_restart: got %b want 01", {Halted, InstrReady});
        end
    endtask

    task automatic test_restart_ignored();
        int edges;
`ifdef SEQ_STATS_EN
        logic [15:0] rt0 = RetireCount;
`endif
        sb.push_back(exp_of(16'h0C21));
        send(16'h0C21, edges);
        Restart = 1'b1;
        tick();
        Restart = 1'b0;
        checks++;
        if ({Wen, WA, Halted} !== {1'b1, 4'hC, 1'b0}) begin
            errors++;
            $display("FAIL restart_ignored_wb: got %h want %h", {Wen, WA, Halted}, {1'b1, 4'hC, 1'b0});
        end
        tick();
`ifdef SEQ_STATS_EN
        checks++;
        if (RetireCount !== rt0 + 16'd1) begin
            errors++;
            $display("FAIL restart_ignored_stats: got %0d want %0d", RetireCount, rt0 + 16'd1);
        end
`endif
    endtask

    task automatic test_reset_midop();
        int edges;
        send(16'h0789, edges);
        tick();
        checks++;
        if ({Wen, WA} !== {1'b1, 4'h7}) begin
            errors++;
            $display("FAIL midop_wb: got %h want %h", {Wen, WA}, {1'b1, 4'h7});
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({Wen, Op, WA, RAA, Busy, InstrReady} !== {1'b0, 3'b010, 4'h0, 4'h0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL midop_async_reset: got %h want %h", {Wen, Op, WA, RAA, Busy, InstrReady},
                {1'b0, 3'b010, 4'h0, 4'h0, 1'b0, 1'b1});
        end
        tick();
        rst_n = 1'b1;
        sb.push_back(exp_of(16'h0ABC));
        send(16'h0ABC, edges);
        checks++;
        if (edges !== 1) begin errors++; $display("FAIL midop_first_accept: edges %0d want 1", edges); end
        repeat (3) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_add();
        test_back_to_back();
        test_brf_taken();
        test_skip_discard();
        test_brf_not_taken();
        test_illegal_halt();
        test_restart_ignored();
        test_reset_midop();
        repeat (3) tick();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover: %0d pending write-backs, want 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
